// File: rtl/pll_reset_supervisor.sv
// pll_reset_supervisor
// Controls the PLL reset/lock handshake on the free-running reference clock.
// The supervisor pulses the PLL reset, waits for lock with a timeout, and
// qualifies lock as stable before it releases the core reset. It re-pulses
// the PLL when lock is lost or software asks for it. After repeated lock
// timeouts it escalates to a sticky fault state.
//
// Optional feature macro: PLL_SUPERVISOR_LOSS_COUNT_EN
//   defined   -> lock_lost_count counts lock-loss events seen in RUN and
//                saturates at 255
//   undefined -> no counter logic is built and lock_lost_count reads 8'd0
module pll_reset_supervisor #(
    parameter int RST_PULSE_CYCLES   = 16,
    parameter int LOCK_TIMEOUT       = 74250,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [7:0] lock_lost_count
);

    // Each counter is sized to its own parameter. The minimum width is one
    // bit so that a parameter value of 1 still gives a legal vector.
    localparam int PULSE_W   = (RST_PULSE_CYCLES   > 1) ? $clog2(RST_PULSE_CYCLES)   : 1;
    localparam int TIMEOUT_W = (LOCK_TIMEOUT       > 1) ? $clog2(LOCK_TIMEOUT)       : 1;
    localparam int STABLE_W  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;

    localparam logic [PULSE_W-1:0]   PULSE_LAST   = PULSE_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]           RETRY_LIMIT  = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PULSE     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic                 sync_meta_r;
    logic                 locked_sync_r;     // pll_locked after two refclk flops
    logic [PULSE_W-1:0]   pulse_cnt_r;
    logic [PULSE_W-1:0]   pulse_cnt_next_s;
    logic [TIMEOUT_W-1:0] wait_cnt_r;
    logic [TIMEOUT_W-1:0] wait_cnt_next_s;
    logic [STABLE_W-1:0]  stable_cnt_r;
    logic [STABLE_W-1:0]  stable_cnt_next_s;
    logic [1:0]           retry_r;
    logic [1:0]           retry_next_s;
    logic [1:0]           retry_inc_s;
    logic                 pll_rst_r;
    logic                 core_reset_r;
    logic                 fault_r;

    // Bring the asynchronous PLL lock indication into the refclk domain.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_meta_r   <= 1'b0;
            locked_sync_r <= 1'b0;
        end else begin
            sync_meta_r   <= pll_locked;
            locked_sync_r <= sync_meta_r;
        end
    end

    // Choose the next state and the next retry count.
    // In STABLE a software request takes precedence over a lock drop.
    always_comb begin
        state_next_s = state_r;
        retry_next_s = retry_r;
        retry_inc_s  = (retry_r == 2'd3) ? 2'd3 : (retry_r + 2'd1);
        case (state_r)
            ST_PULSE: begin
                if (pulse_cnt_r == PULSE_LAST) begin
                    state_next_s = ST_WAIT_LOCK;
                end else begin
                    state_next_s = ST_PULSE;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_sync_r) begin
                    state_next_s = ST_STABLE;
                end else if (wait_cnt_r == TIMEOUT_LAST) begin
                    retry_next_s = retry_inc_s;
                    if (retry_inc_s == RETRY_LIMIT) begin
                        state_next_s = ST_FAULT;
                    end else begin
                        state_next_s = ST_PULSE;
                    end
                end else begin
                    state_next_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (relock_req) begin
                    state_next_s = ST_PULSE;
                end else if (!locked_sync_r) begin
                    state_next_s = ST_WAIT_LOCK;
                end else if (stable_cnt_r == STABLE_LAST) begin
                    state_next_s = ST_RUN;
                    retry_next_s = 2'd0;
                end else begin
                    state_next_s = ST_STABLE;
                end
            end
            ST_RUN: begin
                if (!locked_sync_r || relock_req) begin
                    state_next_s = ST_PULSE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (relock_req) begin
                    state_next_s = ST_PULSE;
                    retry_next_s = 2'd0;
                end else begin
                    state_next_s = ST_FAULT;
                end
            end
            default: begin
                state_next_s = ST_PULSE;
                retry_next_s = 2'd0;
            end
        endcase
    end

    // A phase counter advances only while its state persists. It is cleared
    // whenever the state is entered, re-entered or left.
    always_comb begin
        pulse_cnt_next_s  = {PULSE_W{1'b0}};
        wait_cnt_next_s   = {TIMEOUT_W{1'b0}};
        stable_cnt_next_s = {STABLE_W{1'b0}};
        if (state_r == ST_PULSE && state_next_s == ST_PULSE) begin
            pulse_cnt_next_s = pulse_cnt_r + PULSE_W'(1);
        end else begin
            pulse_cnt_next_s = {PULSE_W{1'b0}};
        end
        if (state_r == ST_WAIT_LOCK && state_next_s == ST_WAIT_LOCK) begin
            wait_cnt_next_s = wait_cnt_r + TIMEOUT_W'(1);
        end else begin
            wait_cnt_next_s = {TIMEOUT_W{1'b0}};
        end
        if (state_r == ST_STABLE && state_next_s == ST_STABLE) begin
            stable_cnt_next_s = stable_cnt_r + STABLE_W'(1);
        end else begin
            stable_cnt_next_s = {STABLE_W{1'b0}};
        end
    end

    // Hold the state, the phase counters and the retry count.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r      <= ST_PULSE;
            pulse_cnt_r  <= {PULSE_W{1'b0}};
            wait_cnt_r   <= {TIMEOUT_W{1'b0}};
            stable_cnt_r <= {STABLE_W{1'b0}};
            retry_r      <= 2'd0;
        end else begin
            state_r      <= state_next_s;
            pulse_cnt_r  <= pulse_cnt_next_s;
            wait_cnt_r   <= wait_cnt_next_s;
            stable_cnt_r <= stable_cnt_next_s;
            retry_r      <= retry_next_s;
        end
    end

    // Decode the registered outputs from the next state so that they line up
    // with the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst_r    <= 1'b1;
            core_reset_r <= 1'b1;
            fault_r      <= 1'b0;
        end else begin
            pll_rst_r    <= (state_next_s == ST_PULSE);
            core_reset_r <= (state_next_s != ST_RUN);
            fault_r      <= (state_next_s == ST_FAULT);
        end
    end

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    logic [7:0] lost_r;

    // Count lock-loss events seen while running, saturating at 255.
    always_ff @(posedge refclk) begin
        if (rst) begin
            lost_r <= 8'd0;
        end else if (state_r == ST_RUN && !locked_sync_r && lost_r != 8'hFF) begin
            lost_r <= lost_r + 8'd1;
        end else begin
            lost_r <= lost_r;
        end
    end

    assign lock_lost_count = lost_r;
`else
    assign lock_lost_count = 8'd0;
`endif

    // rst is ORed into core_reset so the core is held in reset in the same
    // cycle, without waiting for the next clock edge.
    assign pll_rst     = pll_rst_r;
    assign core_reset  = core_reset_r | rst;
    assign fault       = fault_r;
    assign retry_count = retry_r;

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Testbench for pll_reset_supervisor.
// The stimulus process drives the inputs for each cycle. It steps a
// time-stamped reference model and queues the outputs expected after the
// next clock edge. A separate monitor pops one expectation per cycle and
// compares it with the DUT outputs.
module tb_pll_reset_supervisor;

    localparam int RST_PULSE_CYCLES   = 4;
    localparam int LOCK_TIMEOUT       = 20;
    localparam int LOCK_STABLE_CYCLES = 8;
    localparam int MAX_RETRIES        = 2;

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    localparam int P_PULSE  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAULT  = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       core_reset;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] lock_lost_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected output word: {pll_rst, core_reset, fault, retry_count, lock_lost_count}
    logic [12:0] exp_q[$];

    // Reference model state. Each phase is timed by its entry time, not by counters.
    int now_cyc = 0;
    int phase = P_PULSE;
    int t_entry = 0;
    int m_retry = 0;
    int m_lost = 0;
    bit lock_hist[$];   // sampled pll_locked values; locked_s is the value from two edges back

    pll_reset_supervisor #(
        .RST_PULSE_CYCLES  (RST_PULSE_CYCLES),
        .LOCK_TIMEOUT      (LOCK_TIMEOUT),
        .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
        .MAX_RETRIES       (MAX_RETRIES)
    ) dut (
        .refclk         (refclk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .relock_req     (relock_req),
        .pll_rst        (pll_rst),
        .core_reset     (core_reset),
        .fault          (fault),
        .retry_count    (retry_count),
        .lock_lost_count(lock_lost_count)
    );

    always #5 refclk = ~refclk;

    task automatic enter(input int p);
        phase   = p;
        t_entry = now_cyc;
    endtask

    // Advance the model by one clock edge, using the inputs sampled at that edge.
    task automatic model_step(input bit r, input bit l, input bit q);
        bit ls;
        int el;
        now_cyc++;
        ls = lock_hist[0];
        if (r) begin
            enter(P_PULSE);
            m_retry = 0;
            m_lost  = 0;
            lock_hist = '{1'b0, 1'b0};
        end else begin
            el = now_cyc - t_entry;
            case (phase)
                P_PULSE: if (el == RST_PULSE_CYCLES) enter(P_WAIT);
                P_WAIT: begin
                    if (ls) enter(P_STABLE);
                    else if (el == LOCK_TIMEOUT) begin
                        m_retry = (m_retry < 3) ? m_retry + 1 : 3;
                        enter((m_retry == MAX_RETRIES) ? P_FAULT : P_PULSE);
                    end
                end
                P_STABLE: begin
                    if (q) enter(P_PULSE);
                    else if (!ls) enter(P_WAIT);
                    else if (el == LOCK_STABLE_CYCLES) begin
                        enter(P_RUN);
                        m_retry = 0;
                    end
                end
                P_RUN: begin
                    if (!ls || q) begin
                        if (!ls && m_lost < 255) m_lost++;
                        enter(P_PULSE);
                    end
                end
                P_FAULT: begin
                    if (q) begin
                        m_retry = 0;
                        enter(P_PULSE);
                    end
                end
                default: enter(P_PULSE);
            endcase
            void'(lock_hist.pop_front());
            lock_hist.push_back(l);
        end
    endtask

    function automatic logic [12:0] expected_word();
        logic [7:0] lost;
        lost = LOSS_EN ? 8'(m_lost) : 8'd0;
        return {(phase == P_PULSE), (phase != P_RUN), (phase == P_FAULT), 2'(m_retry), lost};
    endfunction

    // Drive one cycle of inputs, queue the expected response, and wait for the next edge.
    task automatic drive(input bit r, input bit l, input bit q);
        rst = r;
        pll_locked = l;
        relock_req = q;
        model_step(r, l, q);
        exp_q.push_back(expected_word());
        if (r) begin
            #1;
            tests_run++;
            if (core_reset !== 1'b1) begin
                tests_failed++;
                $display("FAIL core_reset_on_rst: got %b want 1", core_reset);
            end
        end
        @(posedge refclk);
        #2;
    endtask

    task automatic hold(input int n, input bit r, input bit l, input bit q);
        for (int i = 0; i < n; i++) drive(r, l, q);
    endtask

    // Monitor: compare the DUT outputs with the queued expectation one step after each edge.
    initial begin
        logic [12:0] e;
        logic [12:0] got;
        forever begin
            @(posedge refclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {pll_rst, core_reset, fault, retry_count, lock_lost_count};
                tests_run++;
                if (got !== e) begin
                    tests_failed++;
                    $display("FAIL outputs @%0t: got pll_rst=%b core_reset=%b fault=%b retry=%0d lost=%0d want pll_rst=%b core_reset=%b fault=%b retry=%0d lost=%0d",
                             $time, got[12], got[11], got[10], got[9:8], got[7:0],
                             e[12], e[11], e[10], e[9:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        bit lk;
        lock_hist = '{1'b0, 1'b0};
        // Reset state
        hold(3, 1'b1, 1'b0, 1'b0);
        // Nominal bring-up: lock arrives 10 cycles after reset release
        hold(10, 1'b0, 1'b0, 1'b0);
        hold(40, 1'b0, 1'b1, 1'b0);
        // Re-pulse by request, then a one-cycle lock glitch during STABLE
        drive(1'b0, 1'b1, 1'b1);
        hold(10, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        hold(30, 1'b0, 1'b1, 1'b0);
        // Lock held low: loss in RUN, two timeouts, then FAULT
        hold(70, 1'b0, 1'b0, 1'b0);
        // Fault recovery
        drive(1'b0, 1'b0, 1'b1);
        hold(3, 1'b0, 1'b0, 1'b0);
        hold(30, 1'b0, 1'b1, 1'b0);
        // Lock loss in RUN in the same cycle as relock_req
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        hold(30, 1'b0, 1'b1, 1'b0);
        // rst while running
        drive(1'b1, 1'b1, 1'b0);
        hold(2, 1'b1, 1'b1, 1'b0);
        hold(30, 1'b0, 1'b1, 1'b0);
        // Randomized phase: slowly toggling lock, sparse requests and resets
        lk = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) lk = ~lk;
            drive(($urandom_range(0, 599) == 0), lk, ($urandom_range(0, 99) == 0));
        end
        // Saturation: 260 lock losses while running
        hold(2, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 260; i++) begin
            hold(30, 1'b0, 1'b1, 1'b0);
            hold(3, 1'b0, 1'b0, 1'b0);
        end
        hold(30, 1'b0, 1'b1, 1'b0);
        // Let the monitor drain the queue, with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge refclk);
        #3;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pll_reset_supervisor.md
Name: pll_reset_supervisor

Overview:
- Drives the PLL `rst` input and consumes its `locked` output. It is the controlling end of the PLL rst/locked interface.
- Pulses the PLL reset, waits for lock with a timeout, and qualifies lock as stable before releasing the core reset.
- Re-pulses the PLL on lock loss or on software request. Escalates to a fault state after repeated lock timeouts.
- Runs on the free-running 74.25 MHz reference clock, upstream of every core reset synchronizer.

Parameters:
- RST_PULSE_CYCLES, 16: width of the `pll_rst` pulse in refclk cycles (≥1).
- LOCK_TIMEOUT, 74250: cycles allowed in WAIT_LOCK before a retry (1 ms at 74.25 MHz).
- LOCK_STABLE_CYCLES, 256: consecutive synchronized-locked cycles required before the core is released.
- MAX_RETRIES, 3: number of lock timeouts tolerated before FAULT (≥1).

Ports:
- refclk  in  1  reference clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL locked; asynchronous to refclk, 2-FF synchronized internally.
- relock_req  in  1  single-cycle software request to re-pulse the PLL.
- pll_rst  out  1  reset to the PLL, active high.
- core_reset  out  1  core reset, active high; low only in RUN.
- fault  out  1  high in FAULT.
- retry_count  out  2  lock timeouts since the last RUN entry, saturating at 3.
- lock_lost_count  out  8  lock-loss events seen while in RUN, saturating at 255.

Behaviour:
- Reset values (on `rst`): state=PULSE, all counters=0, sync flops=0, pll_rst=1, core_reset=1, fault=0, retry_count=0, lock_lost_count=0.
- All outputs are registered and decoded from the state register. `locked_s` is `pll_locked` after 2 refclk flops (2-cycle latency).
- PULSE:
  - pll_rst=1, core_reset=1.
  - Counter runs 0..RST_PULSE_CYCLES-1, then go to WAIT_LOCK with the counter cleared.
  - `relock_req` is ignored; the pulse is not restarted.
- WAIT_LOCK:
  - pll_rst=0, core_reset=1.
  - If locked_s=1, go to STABLE with the counter cleared.
  - Else, when the counter reaches LOCK_TIMEOUT-1: increment retry_count. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to PULSE.
  - Lock has priority over timeout in the same cycle.
- STABLE:
  - pll_rst=0, core_reset=1.
  - Counter increments while locked_s=1. When it reaches LOCK_STABLE_CYCLES-1 with locked_s=1, go to RUN.
  - RUN is therefore entered exactly LOCK_STABLE_CYCLES cycles after STABLE entry.
  - If locked_s=0, return to WAIT_LOCK with the timeout counter restarted from 0. This is not a retry.
  - `relock_req` goes to PULSE.
- RUN:
  - pll_rst=0, core_reset=0. retry_count is cleared on entry.
  - If locked_s=0, go to PULSE and increment lock_lost_count.
  - If `relock_req`, go to PULSE.
  - If both occur in the same cycle: one transition to PULSE, lock_lost_count incremented once.
- FAULT:
  - pll_rst=0, core_reset=1, fault=1.
  - Sticky until `relock_req`, which goes to PULSE with retry_count cleared, or until `rst`.
- Counter widths: each counter is sized by $clog2 of its own parameter. retry_count and lock_lost_count saturate and never wrap.
- `rst` mid-operation: returns to PULSE within one cycle. pll_rst is re-asserted on the next edge and core_reset is re-asserted immediately.

Optional Feature:
- Macro: `PLL_SUPERVISOR_LOSS_COUNT_EN`.
- Defined: the lock_lost_count register is implemented as described under Behaviour.
- Undefined: no counter logic is generated and lock_lost_count is tied to 8'd0. All other behaviour is identical.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up: release rst, raise pll_locked 10 cycles later and hold it -> pll_rst high for exactly 4 cycles; core_reset falls 2+8 cycles after the pll_locked rise; fault=0; retry_count=0.
- Lock glitch in STABLE: drop pll_locked for 1 cycle after 5 locked cycles -> no release; core_reset falls 8 cycles after the re-synchronized lock; pll_rst never re-pulses.
- Timeout escalation: hold pll_locked low -> two 4-cycle pll_rst pulses 20 cycles apart in WAIT_LOCK; retry_count goes 1 then 2; fault=1 after the second timeout; pll_rst stays 0.
- Fault recovery: in FAULT, pulse relock_req and then provide lock -> fault=0, a 4-cycle pll_rst pulse, retry_count=0, core_reset eventually falls.
- Lock loss in RUN coinciding with relock_req: drop pll_locked in RUN so locked_s falls in the same cycle as relock_req -> core_reset rises within 1 cycle, a single 4-cycle pll_rst pulse, lock_lost_count 0→1 (stays 0 with the macro undefined).
- Saturation: force 260 lock losses in RUN -> lock_lost_count holds 255.
